// File: rtl/lcd_cmd_scheduler.sv
// Shares the 4-bit LCD nibble interface between two requesters: runs the HD44780
// power-on wait and init sequence, then issues one byte per grant with execution spacing.
module lcd_cmd_scheduler #(
    parameter int unsigned WAIT_POWERON = 750000,
    parameter int unsigned WAIT_CMD     = 2000,
    parameter int unsigned WAIT_CLEAR   = 82000
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       req0_i,
    input  logic       rs0_i,
    input  logic [7:0] data0_i,
    input  logic       req1_i,
    input  logic       rs1_i,
    input  logic [7:0] data1_i,
    output logic       gnt0_o,
    output logic       gnt1_o,
    output logic       lcd_valid_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic [7:0] lcd_data_o,
    output logic       ready_o
);

    localparam int unsigned MAX_PC  = (WAIT_POWERON > WAIT_CLEAR) ? WAIT_POWERON : WAIT_CLEAR;
    localparam int unsigned CNT_MAX = (MAX_PC > WAIT_CMD) ? MAX_PC : WAIT_CMD;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [2:0]  INIT_LEN = 3'd4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        S_POWERON,
        S_INIT,
        S_WAIT,
        S_IDLE
    } state_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [2:0] init_idx_q, init_idx_d;
    logic       last_q, last_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       valid_q, valid_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;

    logic       any_req;
    logic       pick1;
    logic       sel_rs;
    logic [7:0] sel_data;
    logic       do_init;
    logic       do_req;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h28;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    // Clear and return-home need the long execution time; everything else is short.
    function automatic cnt_t spacing(input logic rs, input logic [7:0] data);
        if (!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03)) begin
            return cnt_t'(WAIT_CLEAR);
        end
        return cnt_t'(WAIT_CMD);
    endfunction

    // last_q = 1 means requester 1 was granted most recently; on a tie the other one wins.
    assign any_req  = req0_i | req1_i;
    assign pick1    = req1_i & (~req0_i | ~last_q);
    assign sel_rs   = pick1 ? rs1_i : rs0_i;
    assign sel_data = pick1 ? data1_i : data0_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        init_idx_d = init_idx_q;
        last_d     = last_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        valid_d    = 1'b0;
        rs_d       = rs_q;
        data_d     = data_q;
        do_init    = 1'b0;
        do_req     = 1'b0;

        case (state_q)
            S_POWERON: begin
                if (cnt_q == cnt_t'(WAIT_POWERON - 1)) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            S_INIT: begin
                do_init = 1'b1;
            end
            S_WAIT: begin
                // Expiry issues directly so consecutive strobes are exactly the spacing apart.
                if (cnt_q > cnt_t'(1)) begin
                    cnt_d = cnt_q - cnt_t'(1);
                end else if (init_idx_q != INIT_LEN) begin
                    do_init = 1'b1;
                end else if (any_req) begin
                    do_req = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_IDLE: begin
                if (any_req) begin
                    do_req = 1'b1;
                end
            end
            default: begin
                state_d = S_POWERON;
                cnt_d   = '0;
            end
        endcase

        if (do_init) begin
            valid_d    = 1'b1;
            rs_d       = 1'b0;
            data_d     = init_byte(init_idx_q[1:0]);
            init_idx_d = init_idx_q + 3'd1;
            cnt_d      = spacing(1'b0, init_byte(init_idx_q[1:0]));
            state_d    = S_WAIT;
        end

        if (do_req) begin
            valid_d = 1'b1;
            gnt0_d  = ~pick1;
            gnt1_d  = pick1;
            rs_d    = sel_rs;
            data_d  = sel_data;
            last_d  = pick1;
            cnt_d   = spacing(sel_rs, sel_data);
            state_d = S_WAIT;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_POWERON;
            cnt_q      <= '0;
            init_idx_q <= '0;
            last_q     <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            valid_q    <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            init_idx_q <= init_idx_d;
            last_q     <= last_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            valid_q    <= valid_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
        end
    end

    assign gnt0_o      = gnt0_q;
    assign gnt1_o      = gnt1_q;
    assign lcd_valid_o = valid_q;
    assign lcd_rs_o    = rs_q;
    assign lcd_rw_o    = 1'b0;
    assign lcd_data_o  = data_q;
    assign ready_o     = (state_q == S_IDLE);

`ifndef SYNTHESIS
    a_valid_single : assert property (@(posedge clock_i) disable iff (reset_i) valid_q |=> !valid_q);
    a_gnt_onehot   : assert property (@(posedge clock_i) !(gnt0_q && gnt1_q));
`endif

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Scoreboard bench for lcd_cmd_scheduler: expected strobes (byte, source, cycle) are queued
// as stimulus is issued and compared when lcd_valid fires.
module tb_lcd_cmd_scheduler;

    localparam int P_PON   = 10;
    localparam int P_CMD   = 4;
    localparam int P_CLEAR = 8;

    typedef struct {
        logic [8:0] byte_v;   // {rs, data}
        int         src;      // 0/1 requester, 2 = internal init byte
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       srst;
    logic       req0, rs0, req1, rs1;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, lcd_valid, lcd_rs, lcd_rw, ready;
    logic [7:0] lcd_data;

    exp_t       sb[$];
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int         cyc = -1;
    int         n_checks = 0;
    int         n_errors = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] init_b [4] = '{8'h28, 8'h06, 8'h0C, 8'h01};

    always #5 clk = ~clk;

    lcd_cmd_scheduler #(
        .WAIT_POWERON(P_PON),
        .WAIT_CMD    (P_CMD),
        .WAIT_CLEAR  (P_CLEAR)
    ) dut (
        .clock_i    (clk),
        .reset_i    (srst),
        .req0_i     (req0),
        .rs0_i      (rs0),
        .data0_i    (data0),
        .req1_i     (req1),
        .rs1_i      (rs1),
        .data1_i    (data1),
        .gnt0_o     (gnt0),
        .gnt1_o     (gnt1),
        .lcd_valid_o(lcd_valid),
        .lcd_rs_o   (lcd_rs),
        .lcd_rw_o   (lcd_rw),
        .lcd_data_o (lcd_data),
        .ready_o    (ready)
    );

    // cyc = index of the most recent edge, 0 being the first edge with reset low.
    always @(posedge clk) begin
        if (srst) cyc <= -1;
        else      cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int spacing(input logic [8:0] b);
        if (!b[8] && b[7:0] >= 8'h01 && b[7:0] <= 8'h03) return P_CLEAR;
        return P_CMD;
    endfunction

    task automatic send(input int src, input logic [8:0] b, inout int t);
        if (src == 0) q0.push_back(b);
        else          q1.push_back(b);
        sb.push_back(exp_t'{b, src, t});
        t += spacing(b);
    endtask

    task automatic push_init(output int t);
        t = P_PON;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(exp_t'{{1'b0, init_b[i]}, 2, t});
            t += spacing({1'b0, init_b[i]});
        end
    endtask

    task automatic wait_cyc(input int target);
        int budget = 500;
        while (cyc != target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (cyc != target) check_eq("timeout_cyc", cyc, target);
    endtask

    task automatic check_reset();
        check_eq("rst_gnt0",  gnt0, 0);
        check_eq("rst_gnt1",  gnt1, 0);
        check_eq("rst_valid", lcd_valid, 0);
        check_eq("rst_rs",    lcd_rs, 0);
        check_eq("rst_data",  lcd_data, 0);
        check_eq("rst_rw",    lcd_rw, 0);
        check_eq("rst_ready", ready, 0);
    endtask

    // One-cycle reset pulse; returns the cycle at which the post-clear wait expires.
    task automatic reset_pulse(output int t);
        srst = 1'b1;
        @(negedge clk);
        check_reset();
        push_init(t);
        srst = 1'b0;
    endtask

    // Requester models: present the queue head, advance only after seeing the grant.
    initial begin
        req0 = 1'b0; rs0 = 1'b0; data0 = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (gnt0 && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                req0 = 1'b1; rs0 = q0[0][8]; data0 = q0[0][7:0];
            end else begin
                req0 = 1'b0;
            end
        end
    end

    initial begin
        req1 = 1'b0; rs1 = 1'b0; data1 = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (gnt1 && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                req1 = 1'b1; rs1 = q1[0][8]; data1 = q1[0][7:0];
            end else begin
                req1 = 1'b0;
            end
        end
    end

    // Monitor: every strobe is matched against the scoreboard head.
    initial begin
        exp_t e;
        int   src;
        forever begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                check_eq("gnt_with_valid", lcd_valid, 1);
                check_eq("gnt_onehot", gnt0 & gnt1, 0);
            end
            if (lcd_valid) begin
                check_eq("valid_consecutive", prev_valid, 0);
                check_eq("strobe_rw", lcd_rw, 0);
                if (sb.size() == 0) begin
                    check_eq("strobe_expected", sb.size(), 1);
                end else begin
                    e   = sb.pop_front();
                    src = gnt0 ? 0 : (gnt1 ? 1 : 2);
                    $display("strobe cyc=%0d rs=%0b data=%02h src=%0d (exp cyc=%0d rs=%0b data=%02h src=%0d)",
                             cyc, lcd_rs, lcd_data, src, e.cyc, e.byte_v[8], e.byte_v[7:0], e.src);
                    check_eq("strobe_data", lcd_data, e.byte_v[7:0]);
                    check_eq("strobe_rs",   lcd_rs,   e.byte_v[8]);
                    check_eq("strobe_src",  src,      e.src);
                    check_eq("strobe_cyc",  cyc,      e.cyc);
                end
            end
            prev_valid = lcd_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t0;
        srst = 1'b1;
        repeat (3) @(negedge clk);

        // Power-on and init sequence with no requests
        check_reset();
        push_init(t);
        srst = 1'b0;
        wait_cyc(t - 1);
        check_eq("init_ready_low", ready, 0);
        wait_cyc(t);
        check_eq("init_ready_high", ready, 1);
        check_eq("init_drained", sb.size(), 0);

        // Contention: strict alternation from a fresh pointer
        t = cyc + 2;
        for (int i = 0; i < 3; i++) begin
            send(0, 9'h141 + 9'(i), t);
            send(1, 9'h161 + 9'(i), t);
        end
        wait_cyc(t);
        check_eq("cont_ready", ready, 1);
        check_eq("cont_drained", sb.size(), 0);

        // Single request from IDLE
        t0 = cyc + 2;
        t  = t0;
        send(0, 9'h141, t);
        wait_cyc(t0 - 1);
        check_eq("single_ready_before", ready, 1);
        wait_cyc(t0);
        check_eq("single_ready_drop", ready, 0);
        wait_cyc(t0 + 3);
        check_eq("single_ready_held", ready, 0);
        check_eq("single_data_held", lcd_data, 8'h41);
        check_eq("single_rs_held", lcd_rs, 1);
        wait_cyc(t0 + 4);
        check_eq("single_ready_back", ready, 1);

        // Spacing after clear vs. ordinary command
        t = cyc + 2;
        send(1, 9'h001, t);
        send(1, 9'h15A, t);
        wait_cyc(t);
        check_eq("clear_ready", ready, 1);

        t = cyc + 2;
        send(1, 9'h080, t);
        send(1, 9'h15A, t);
        wait_cyc(t);
        check_eq("cmd_ready", ready, 1);

        // Boundaries of the long-wait byte range, and rs=1 with a clear code
        t = cyc + 2;
        send(0, 9'h101, t);
        send(0, 9'h003, t);
        send(0, 9'h004, t);
        send(0, 9'h002, t);
        send(0, 9'h15A, t);
        wait_cyc(t);
        check_eq("range_ready", ready, 1);
        check_eq("range_drained", sb.size(), 0);

        // Request held through reset and init: served right after the clear wait
        q0.push_back(9'h141);
        reset_pulse(t);
        sb.push_back(exp_t'{9'h141, 0, t});
        wait_cyc(t);
        check_eq("during_init_ready", ready, 0);
        wait_cyc(t + 4);
        check_eq("during_init_ready_back", ready, 1);

        // Reset in the middle of a clear wait with a byte pending on requester 1
        t = cyc + 2;
        send(1, 9'h001, t);
        q1.push_back(9'h162);
        wait_cyc(cyc + 4);
        check_eq("mid_req1_pending", req1, 1);
        reset_pulse(t);
        check_eq("mid_pending_kept", q1.size(), 1);
        sb.push_back(exp_t'{9'h162, 1, t});
        wait_cyc(t);
        check_eq("mid_ready_low", ready, 0);
        wait_cyc(t + 4);
        check_eq("mid_ready_back", ready, 1);
        check_eq("final_drained", sb.size(), 0);
        check_eq("final_q1_empty", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_scheduler.md
# lcd_cmd_scheduler

Command scheduler that owns the 4-bit LCD interface and shares it between two independent command/character requesters. After reset it runs the HD44780 power-on wait and initialisation sequence itself. It then grants requesters round-robin, presenting one byte (rs, data) per grant and enforcing the controller's post-command execution delay before the next byte. It sits between the text/cursor producers and the LCD nibble interface, replacing ad-hoc sequencing in the top level.

## Interface
- WAIT_POWERON, 750000: cycles to wait after reset before the first init command (15 ms at 50 MHz).
- WAIT_CMD, 2000: cycles from one lcd_valid strobe to the next, for ordinary commands and data (40 us); must be >= 2.
- WAIT_CLEAR, 82000: spacing after a clear (0x01) or return-home (0x02/0x03) command with rs=0 (1.64 ms); must be >= 2.
- clock  in  1  system clock (CLK_50MHZ domain).
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  requester n has a byte pending; held high until gntn.
- rs0 / rs1  in  1  register select for requester n (0 = command, 1 = data); stable while reqn is high.
- data0 / data1  in  8  byte for requester n; stable while reqn is high.
- gnt0 / gnt1  out  1  one-cycle pulse: requester n's byte was issued this cycle.
- lcd_valid  out  1  one-cycle strobe to the nibble interface: start a transfer.
- lcd_rs  out  1  register select for the current transfer; held until the next strobe.
- lcd_rw  out  1  constant 0 (write only).
- lcd_data  out  8  byte for the current transfer; held until the next strobe.
- ready  out  1  high in IDLE only: the scheduler is accepting requests.

## Operation
- States: POWERON → INIT → WAIT → IDLE. From IDLE or an expiring WAIT, the scheduler issues a byte and returns to WAIT.
- Reset values: state POWERON; counter 0; gnt0 = gnt1 = 0; lcd_valid = 0; lcd_rs = 0; lcd_data = 0x00; lcd_rw = 0; ready = 0; round-robin pointer favours requester 0.
- POWERON: counts WAIT_POWERON cycles, then enters INIT.
- INIT: issues the fixed sequence 0x28 (function set), 0x06 (entry mode), 0x0C (display on), 0x01 (clear), all with rs=0.
  - Each init byte goes through WAIT with the correct spacing; the clear uses WAIT_CLEAR.
  - No gnt is asserted during POWERON or INIT, and requests are ignored.
- Issue: on the issuing edge the scheduler sets
  - lcd_valid = 1,
  - gntn = 1 for the selected requester,
  - lcd_rs / lcd_data = rsn / datan,
  - the counter to the spacing value (WAIT_CLEAR for rs=0 bytes 0x01–0x03, otherwise WAIT_CMD).
- WAIT: counts down to zero.
  - At expiry with any req high, it issues immediately. There is no IDLE bubble, so back-to-back strobes are exactly the spacing value apart.
  - At expiry with no req high, it goes to IDLE.
- Arbitration:
  - If only one req is high, that requester wins.
  - If both are high, the requester not granted most recently wins; the pointer updates on every grant.
- Handshake:
  - The requester must hold reqn/rsn/datan stable until it sees gntn.
  - If reqn is still high in the cycle after gntn, it is a new byte.
- Reset while in any state aborts the current transfer: no gnt, lcd_valid low, and the full POWERON+INIT sequence restarts. Bytes that were pending are not consumed.

## Timing
- Let cycle 0 be the first edge with reset low.
- The first lcd_valid (0x28) occurs at cycle WAIT_POWERON.
- The next init strobes follow at +WAIT_CMD, +WAIT_CMD and +WAIT_CMD.
- ready rises WAIT_CLEAR cycles after the 0x01 strobe, unless a req is already high. In that case the scheduler issues on that edge and ready stays low.
- IDLE latency: a req first seen high at edge N gives gnt and lcd_valid high in cycle N+1, and ready low from N+1.
- lcd_valid, gnt0 and gnt1 are never high for two consecutive cycles.
- gnt0 and gnt1 are never high together.

## Test plan
- Init sequence (WAIT_POWERON=10, WAIT_CMD=4, WAIT_CLEAR=8, no requests) → lcd_valid strobes at cycles 10, 14, 18, 22 with lcd_data 0x28, 0x06, 0x0C, 0x01 and rs=0. ready rises at cycle 30. No gnt at any point.
- Single request: in IDLE, req0=1, rs0=1, data0=0x41 → gnt0 and lcd_valid one cycle later; lcd_data=0x41, lcd_rs=1; ready low for 4 cycles.
- Contention: req0 and req1 held high with 3 bytes each (0x41–0x43 and 0x61–0x63) → issue order 0x41, 0x61, 0x42, 0x62, 0x43, 0x63, strobes exactly 4 cycles apart.
- Clear spacing: req1 rs=0 data=0x01, then req1 rs=1 data=0x5A held high → second strobe 8 cycles after the first. Repeating with data=0x80 instead of 0x01 gives a spacing of 4.
- Requests during init: req0 high from cycle 0 → no gnt0 before cycle 30; 0x41 issued at cycle 30.
- Mid-operation reset: reset pulsed for one cycle during WAIT with req1 pending → outputs return to reset values next cycle. The init sequence repeats with identical timing, and req1 is granted only after the new clear wait.
